// File: rtl/parking_pkg.sv
// Shared definitions for the parking lane sequencer.
// Holds the lane state encoding, the opening hour and the hour bus width.
package parking_pkg;

    localparam int HOUR_W = 5;
    localparam logic [HOUR_W-1:0] HOUR_OPEN = 5'd8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        PASSING = 3'd3,
        CLOSE   = 3'd4,
        REJECT  = 3'd5
    } lane_state_e;

endpackage

// File: rtl/gate_lane.sv
// One barrier lane sequencer (entry or exit).
//
//   state   | meaning
//   IDLE    | waiting for an arrival edge during opening hours
//   CHECK   | one cycle: latch uni flag, decide admission
//   OPEN    | barrier up, timeout counter running
//   PASSING | car on the pass loop, barrier up
//   CLOSE   | barrier down, waiting for arrive loop to clear
//   REJECT  | full lamp on, waiting for arrive loop to clear
//
// Ports:
//   clk, rst              - system clock, async active-high reset
//   hour_open_i           - current hour is within opening hours
//   arrive_i, pass_i      - debounced loop sensors
//   is_uni_i              - uni card level, sampled in CHECK
//   uni_vac_i, vac_i      - vacancy flags (used only when CHECK_VACANCY=1)
//   barrier_o, lamp_o     - registered barrier and full-lamp outputs
//   evt_req_o, evt_uni_o  - one-cycle pass-complete strobe and its uni flag
module gate_lane
    import parking_pkg::*;
#(
    parameter bit CHECK_VACANCY = 1'b1,
    parameter int OPEN_TIMEOUT  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic hour_open_i,
    input  logic arrive_i,
    input  logic pass_i,
    input  logic is_uni_i,
    input  logic uni_vac_i,
    input  logic vac_i,
    output logic barrier_o,
    output logic lamp_o,
    output logic evt_req_o,
    output logic evt_uni_o
);

    localparam int TO_W = $clog2(OPEN_TIMEOUT + 1);

    lane_state_e     state_q;
    logic            arrive_prev_q;
    logic            pass_prev_q;
    logic            uni_q;
    logic            barrier_q;
    logic            lamp_q;
    logic [TO_W-1:0] to_cnt_q;

    logic arrive_rise, pass_rise, pass_fall, admit;

    assign arrive_rise = arrive_i & ~arrive_prev_q;
    assign pass_rise   = pass_i & ~pass_prev_q;
    assign pass_fall   = ~pass_i & pass_prev_q;

    always_comb begin
        admit = 1'b1;
        if (CHECK_VACANCY)
            admit = is_uni_i ? (uni_vac_i | vac_i) : vac_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            arrive_prev_q <= 1'b0;
            pass_prev_q   <= 1'b0;
            uni_q         <= 1'b0;
            barrier_q     <= 1'b0;
            lamp_q        <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            arrive_prev_q <= arrive_i;
            pass_prev_q   <= pass_i;
            case (state_q)
                IDLE: begin
                    if (arrive_rise && hour_open_i)
                        state_q <= CHECK;
                end
                CHECK: begin
                    uni_q <= is_uni_i;
                    if (admit) begin
                        state_q   <= OPEN;
                        barrier_q <= 1'b1;
                        to_cnt_q  <= '0;
                    end else begin
                        state_q <= REJECT;
                        lamp_q  <= 1'b1;
                    end
                end
                OPEN: begin
                    // Saturating count; the step that reaches OPEN_TIMEOUT
                    // also drops the barrier, so it stays up OPEN_TIMEOUT cycles.
                    if (to_cnt_q != TO_W'(OPEN_TIMEOUT))
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (pass_rise) begin
                        state_q <= PASSING;
                    end else if (to_cnt_q == TO_W'(OPEN_TIMEOUT - 1)) begin
                        state_q   <= CLOSE;
                        barrier_q <= 1'b0;
                    end
                end
                PASSING: begin
                    if (pass_fall) begin
                        state_q   <= CLOSE;
                        barrier_q <= 1'b0;
                    end
                end
                CLOSE: begin
                    if (!arrive_i)
                        state_q <= IDLE;
                end
                REJECT: begin
                    if (!arrive_i) begin
                        state_q <= IDLE;
                        lamp_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    barrier_q <= 1'b0;
                    lamp_q    <= 1'b0;
                end
            endcase
        end
    end

    assign barrier_o = barrier_q;
    assign lamp_o    = lamp_q;
    // Combinational so the arbiter can register the pulse one cycle after
    // the debounced pass edge.
    assign evt_req_o = (state_q == PASSING) && pass_fall;
    assign evt_uni_o = uni_q;

endmodule

// File: rtl/sensor_debounce.sv
// Loop sensor conditioner: 2-FF synchronizer followed by a stability counter.
// Ports:
//   clk, rst - system clock, async active-high reset
//   raw_i    - raw loop sensor level
//   deb_o    - debounced level; takes the new value after DEBOUNCE_CYCLES
//              consecutive equal synchronized samples
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic deb_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             deb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            // cnt_q counts differing samples already seen; any agreeing
            // sample restarts the run.
            if (sync_q[1] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_q <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit lane sequencer feeding the occupancy manager.
// Debounces four loop sensors, runs one lane FSM per barrier and arbitrates
// the car_entered / car_exited pulses (exit wins, entry deferred one cycle).
// Ports:
//   clk, rst                          - system clock, async active-high reset
//   current_hour                      - hour of day 0..23
//   entry_/exit_ arrive, is_uni, pass - raw loop sensors and uni card level
//   uni_is_vacated_space, is_vacated_space - vacancy flags for entry admission
//   entry_barrier_open, exit_barrier_open  - barrier actuators
//   entry_full_lamp                   - refused-entry indicator
//   car_entered/is_uni_car_entered, car_exited/is_uni_car_exited - event pulses
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OPEN_TIMEOUT    = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HOUR_W-1:0] current_hour,
    input  logic              entry_arrive,
    input  logic              entry_is_uni,
    input  logic              entry_pass,
    input  logic              exit_arrive,
    input  logic              exit_is_uni,
    input  logic              exit_pass,
    input  logic              uni_is_vacated_space,
    input  logic              is_vacated_space,
    output logic              entry_barrier_open,
    output logic              exit_barrier_open,
    output logic              entry_full_lamp,
    output logic              car_entered,
    output logic              is_uni_car_entered,
    output logic              car_exited,
    output logic              is_uni_car_exited
);

    // Asserts asynchronously, releases two clocks after rst falls.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    logic ent_arr_deb, ent_pass_deb, ext_arr_deb, ext_pass_deb;
    logic hour_open;
    logic ent_lamp, ext_lamp;
    logic ent_req, ent_uni, ext_req, ext_uni;

    assign hour_open = (current_hour >= HOUR_OPEN);

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ent_arr (
        .clk(clk), .rst(rst_int), .raw_i(entry_arrive), .deb_o(ent_arr_deb));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ent_pass (
        .clk(clk), .rst(rst_int), .raw_i(entry_pass), .deb_o(ent_pass_deb));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ext_arr (
        .clk(clk), .rst(rst_int), .raw_i(exit_arrive), .deb_o(ext_arr_deb));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ext_pass (
        .clk(clk), .rst(rst_int), .raw_i(exit_pass), .deb_o(ext_pass_deb));

    gate_lane #(.CHECK_VACANCY(1'b1), .OPEN_TIMEOUT(OPEN_TIMEOUT)) u_entry (
        .clk(clk), .rst(rst_int), .hour_open_i(hour_open),
        .arrive_i(ent_arr_deb), .pass_i(ent_pass_deb), .is_uni_i(entry_is_uni),
        .uni_vac_i(uni_is_vacated_space), .vac_i(is_vacated_space),
        .barrier_o(entry_barrier_open), .lamp_o(ent_lamp),
        .evt_req_o(ent_req), .evt_uni_o(ent_uni));

    gate_lane #(.CHECK_VACANCY(1'b0), .OPEN_TIMEOUT(OPEN_TIMEOUT)) u_exit (
        .clk(clk), .rst(rst_int), .hour_open_i(hour_open),
        .arrive_i(ext_arr_deb), .pass_i(ext_pass_deb), .is_uni_i(exit_is_uni),
        .uni_vac_i(uni_is_vacated_space), .vac_i(is_vacated_space),
        .barrier_o(exit_barrier_open), .lamp_o(ext_lamp),
        .evt_req_o(ext_req), .evt_uni_o(ext_uni));

    // The exit lane never refuses, so its lamp is constant 0.
    assign entry_full_lamp = ent_lamp | ext_lamp;

    logic pend_q, pend_uni_q;
    logic entered_q, entered_uni_q, exited_q, exited_uni_q;
    logic entry_req_d, entry_uni_d;

    always_comb begin
        entry_req_d = ent_req | pend_q;
        entry_uni_d = ent_req ? ent_uni : pend_uni_q;
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            pend_q        <= 1'b0;
            pend_uni_q    <= 1'b0;
            entered_q     <= 1'b0;
            entered_uni_q <= 1'b0;
            exited_q      <= 1'b0;
            exited_uni_q  <= 1'b0;
        end else begin
            entered_q     <= 1'b0;
            entered_uni_q <= 1'b0;
            exited_q      <= 1'b0;
            exited_uni_q  <= 1'b0;
            if (ext_req) begin
                exited_q     <= 1'b1;
                exited_uni_q <= ext_uni;
                pend_q       <= entry_req_d;
                pend_uni_q   <= entry_req_d & entry_uni_d;
            end else if (entry_req_d) begin
                entered_q     <= 1'b1;
                entered_uni_q <= entry_uni_d;
                pend_q        <= 1'b0;
                pend_uni_q    <= 1'b0;
            end
        end
    end

    assign car_entered        = entered_q;
    assign is_uni_car_entered = entered_uni_q;
    assign car_exited         = exited_q;
    assign is_uni_car_exited  = exited_uni_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller with an event scoreboard.
module tb_parking_gate_controller;

    localparam int DEB = 4;
    localparam int TO  = 1000;
    // raw sensor change -> debounced edge (2 + DEB) -> registered pulse (+1)
    localparam int EVT_LAT = 2 + DEB + 1;
    localparam int BAR_LAT = 2 + DEB + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] current_hour;
    logic entry_arrive, entry_is_uni, entry_pass;
    logic exit_arrive, exit_is_uni, exit_pass;
    logic uni_is_vacated_space, is_vacated_space;
    logic entry_barrier_open, exit_barrier_open, entry_full_lamp;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;

    parking_gate_controller #(.DEBOUNCE_CYCLES(DEB), .OPEN_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .current_hour(current_hour),
        .entry_arrive(entry_arrive), .entry_is_uni(entry_is_uni), .entry_pass(entry_pass),
        .exit_arrive(exit_arrive), .exit_is_uni(exit_is_uni), .exit_pass(exit_pass),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .entry_barrier_open(entry_barrier_open), .exit_barrier_open(exit_barrier_open),
        .entry_full_lamp(entry_full_lamp),
        .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit kind;   // 0 = entry, 1 = exit
        bit uni;
        int at;     // cycle in which the pulse is required
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit kind, input bit uni, input int at);
        exp_t e;
        e.kind = kind;
        e.uni  = uni;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Event monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("qual_idle", {30'd0, is_uni_car_entered & ~car_entered,
                              is_uni_car_exited & ~car_exited}, 32'd0);
            chk("pulse_overlap", {31'd0, car_entered & car_exited}, 32'd0);
            if (car_entered || car_exited) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {30'd0, car_entered, car_exited}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("evt_kind", {30'd0, car_entered, car_exited},
                        mon_e.kind ? 32'd1 : 32'd2);
                    chk("evt_uni", {31'd0, car_entered ? is_uni_car_entered : is_uni_car_exited},
                        {31'd0, mon_e.uni});
                    chk("evt_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    int c;

    initial begin
        rst = 1'b1;
        current_hour = 5'd9;
        entry_arrive = 0; entry_is_uni = 0; entry_pass = 0;
        exit_arrive = 0; exit_is_uni = 0; exit_pass = 0;
        uni_is_vacated_space = 1; is_vacated_space = 1;
        tick(3);
        chk("reset_outputs", {25'd0, entry_barrier_open, exit_barrier_open, entry_full_lamp,
                              car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}, 32'd0);
        rst = 1'b0;
        tick(5);
        chk("post_reset_outputs", {25'd0, entry_barrier_open, exit_barrier_open, entry_full_lamp,
                                   car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}, 32'd0);

        // Uni entry at hour 9; uni level drops after CHECK and must stay latched.
        entry_is_uni = 1; entry_arrive = 1; c = cyc;
        tick(BAR_LAT - 1);
        chk("ent_bar_early", {31'd0, entry_barrier_open}, 32'd0);
        tick(1);
        chk("ent_bar_open", {31'd0, entry_barrier_open}, 32'd1);
        entry_is_uni = 0;
        entry_pass = 1;
        tick(10);
        chk("ent_bar_passing", {31'd0, entry_barrier_open}, 32'd1);
        entry_pass = 0; push(1'b0, 1'b1, cyc + EVT_LAT);
        tick(10);
        chk("ent_bar_closed", {31'd0, entry_barrier_open}, 32'd0);
        entry_arrive = 0;
        tick(10);

        // Non-uni with only uni vacancy: refused.
        is_vacated_space = 0; uni_is_vacated_space = 1; entry_is_uni = 0;
        entry_arrive = 1;
        tick(12);
        chk("reject_lamp", {31'd0, entry_full_lamp}, 32'd1);
        chk("reject_bar", {31'd0, entry_barrier_open}, 32'd0);
        entry_arrive = 0;
        tick(10);
        chk("reject_lamp_clear", {31'd0, entry_full_lamp}, 32'd0);

        // Uni with only uni vacancy: admitted; vacancy withdrawn while open;
        // no pass, so the barrier times out with no event.
        entry_is_uni = 1; entry_arrive = 1; c = cyc;
        tick(BAR_LAT);
        chk("uni_admit_bar", {31'd0, entry_barrier_open}, 32'd1);
        uni_is_vacated_space = 0;
        tick(TO - 1);
        chk("timeout_last_open", {31'd0, entry_barrier_open}, 32'd1);
        tick(1);
        chk("timeout_closed", {31'd0, entry_barrier_open}, 32'd0);
        entry_arrive = 0; entry_is_uni = 0;
        uni_is_vacated_space = 1; is_vacated_space = 1;
        tick(10);

        // Hour 6: both lanes ignore arrivals and passes.
        current_hour = 5'd6;
        entry_arrive = 1; exit_arrive = 1;
        tick(15);
        entry_pass = 1; exit_pass = 1;
        tick(10);
        chk("h6_bars", {30'd0, entry_barrier_open, exit_barrier_open}, 32'd0);
        entry_pass = 0; exit_pass = 0;
        tick(10);
        entry_arrive = 0; exit_arrive = 0;
        tick(10);

        // Hour 8: both lanes run; passes fall together, exit wins.
        current_hour = 5'd8;
        entry_is_uni = 0; exit_is_uni = 1;
        entry_arrive = 1; exit_arrive = 1;
        tick(BAR_LAT);
        chk("h8_bars", {30'd0, entry_barrier_open, exit_barrier_open}, 32'd3);
        entry_pass = 1; exit_pass = 1;
        tick(10);
        entry_pass = 0; exit_pass = 0;
        push(1'b1, 1'b1, cyc + EVT_LAT);
        push(1'b0, 1'b0, cyc + EVT_LAT + 1);
        tick(10);
        chk("h8_closed", {30'd0, entry_barrier_open, exit_barrier_open}, 32'd0);
        entry_arrive = 0; exit_arrive = 0; exit_is_uni = 0;
        tick(10);

        // Glitch of DEB-1 cycles on the entry arrive loop: no admission.
        entry_arrive = 1;
        tick(DEB - 1);
        entry_arrive = 0;
        tick(15);
        chk("glitch_no_change", {30'd0, entry_barrier_open, entry_full_lamp}, 32'd0);

        // Reset during PASSING: barrier drops at once, no event follows.
        entry_arrive = 1;
        tick(BAR_LAT + 2);
        entry_pass = 1;
        tick(10);
        chk("pre_rst_bar", {31'd0, entry_barrier_open}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_bar_now", {31'd0, entry_barrier_open}, 32'd0);
        entry_pass = 0; entry_arrive = 0;
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("post_rst_idle", {30'd0, entry_barrier_open, entry_full_lamp}, 32'd0);

        // Lane is back in IDLE: a fresh non-uni entry completes normally.
        entry_arrive = 1;
        tick(BAR_LAT);
        chk("recover_bar", {31'd0, entry_barrier_open}, 32'd1);
        entry_pass = 1;
        tick(10);
        entry_pass = 0; push(1'b0, 1'b0, cyc + EVT_LAT);
        tick(10);
        entry_arrive = 0;
        tick(20);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Lane sequencer directly upstream of the parking occupancy manager. It debounces the raw loop sensors of one entry lane and one exit lane and runs each barrier through an arrive/check/open/pass/close sequence. It emits the one-cycle `car_entered` / `car_exited` event pulses and the uni/non-uni qualifiers that the occupancy manager counts. Vacancy flags returned by the occupancy manager gate entry admission.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before a debounced sensor changes.
- `OPEN_TIMEOUT`, default 1000: cycles a barrier may stay open with no pass detection before it closes without an event.
- `clk  in  1  single system clock, all logic on rising edge`
- `rst  in  1  asynchronous, active-high reset`
- `current_hour  in  5  hour of day, 0..23`
- `entry_arrive  in  1  raw loop sensor before the entry barrier`
- `entry_is_uni  in  1  uni card presented (level, sampled in CHECK)`
- `entry_pass  in  1  raw loop sensor after the entry barrier`
- `exit_arrive, exit_is_uni, exit_pass  in  1 each  same meaning for the exit lane`
- `uni_is_vacated_space, is_vacated_space  in  1 each  vacancy flags from the occupancy manager`
- `entry_barrier_open, exit_barrier_open  out  1 each  barrier actuator`
- `entry_full_lamp  out  1  "full" indicator for a refused entry`
- `car_entered, is_uni_car_entered  out  1 each  entry event pulse + qualifier`
- `car_exited, is_uni_car_exited  out  1 each  exit event pulse + qualifier`

## Operation
- Each raw sensor passes through a 2-FF synchronizer and then a debouncer. The debounced output takes the new level after `DEBOUNCE_CYCLES` consecutive equal samples; any differing sample restarts the count.
- Both lanes share one FSM template: IDLE, CHECK, OPEN, PASSING, CLOSE, REJECT.
- IDLE -> CHECK on debounced arrive rising edge. Arrivals while `current_hour < 8` are ignored and the lane stays IDLE.
- CHECK (one cycle) latches `is_uni`.
  - Entry admits when the latched uni flag is set and `uni_is_vacated_space | is_vacated_space`, or when the flag is clear and `is_vacated_space`.
  - Exit always admits.
  - Admit -> OPEN. Refuse -> REJECT.
- REJECT: `entry_full_lamp`=1. Returns to IDLE when debounced arrive falls.
- OPEN: barrier=1 and the timeout counter runs.
  - Debounced pass rising -> PASSING.
  - Counter reaching `OPEN_TIMEOUT` -> CLOSE, with no event.
- PASSING: barrier=1. Debounced pass falling -> CLOSE and raises that lane's event request.
- CLOSE: barrier=0. Waits until debounced arrive is 0, then -> IDLE.
- Event arbiter:
  - At most one of `car_entered` / `car_exited` is high in any cycle.
  - A pending entry request is held while an exit pulse is issued that cycle (exit wins). The entry pulse follows in the next cycle.
  - Qualifiers are valid in the pulse cycle and are 0 otherwise.
- Timeout counter width is `$clog2(OPEN_TIMEOUT+1)`. It clears on entry to OPEN and saturates, with no wrap.
- Hour rolling past 7 or 23 mid-sequence does not abort an OPEN/PASSING lane. The event is still issued.

## Timing
- Reset (async assert, sync release) sets every output to 0, all FSMs to IDLE, debounced sensors to 0, counters to 0, and clears pending requests.
- Reset mid-sequence closes barriers immediately and drops the pending event.
- Raw edge to debounced edge: 2 + `DEBOUNCE_CYCLES` cycles.
- Debounced arrive to barrier=1: 2 cycles (IDLE->CHECK, CHECK->OPEN, output registered).
- Debounced pass falling to event pulse: 1 cycle, or 2 if deferred by an exit pulse.
- Event pulses are exactly one cycle wide. Consecutive pulses from the same lane are at least one lane sequence apart.
- Vacancy flags are sampled only in CHECK. Changes while OPEN do not revoke admission.

## Structure
- Package `parking_pkg`: lane state enum (IDLE, CHECK, OPEN, PASSING, CLOSE, REJECT), `HOUR_OPEN = 8`, hour width 5.
- Sub-module `sensor_debounce` (synchronizer + stability counter, parameter `DEBOUNCE_CYCLES`), instantiated 4 times.
- Lane FSM written once as `gate_lane` with a parameter `CHECK_VACANCY` (1 for entry, 0 for exit), instantiated twice. The arbiter lives in the top.

## Test plan
- Hour 9, both vacancy flags 1, uni entry: arrive, then pass high/low. Required: barrier opens 2 cycles after debounce, and `car_entered`=1 with `is_uni_car_entered`=1 for one cycle after pass falls.
- Hour 9, `is_vacated_space`=0, `uni_is_vacated_space`=1, non-uni arrival. Required: `entry_full_lamp`=1, barrier stays 0, no pulse. Lamp clears after arrive drops.
- Hour 6, entry and exit arrivals. Required: both lanes stay IDLE with no barrier activity. Repeat at hour 8 and both lanes operate.
- Entry and exit pass falling in the same cycle. Required: `car_exited` in cycle N+1, then `car_entered` in N+2. The two pulses never overlap.
- Sensor glitch shorter than `DEBOUNCE_CYCLES`. Required: no state change. Separately, open with no pass for `OPEN_TIMEOUT` cycles. Required: barrier closes and no event is issued.
- `rst` asserted during PASSING. Required: barrier 0 immediately, no event after release, lane returns to IDLE.
